// File: rtl/dbg_cmd_gen.sv
// Debug command generator: debounced step/run buttons and a captured 5-bit data word with a valid/ready handshake.
// Define AUTO_STEP_EN to emit repeated step pulses while btn_step stays held.
module dbg_cmd_gen #(
    parameter int unsigned DB_CYCLES     = 1000000,
    parameter int unsigned REPEAT_CYCLES = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_step,
    input  logic       btn_valid,
    input  logic       sw_run,
    input  logic [4:0] sw_in,
    input  logic       ready,
    output logic       step,
    output logic       run,
    output logic [4:0] in,
    output logic       valid,
    output logic       busy
);
    localparam logic [23:0] DB_TC  = 24'(DB_CYCLES - 1);
    localparam logic [23:0] REP_TC = 24'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SEND    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    // bit 0 = step button, bit 1 = valid button, bit 2 = run switch
    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [2:0]  r_db;
    logic [1:0]  r_db_d;
    logic [23:0] r_db_cnt [3];
    logic [4:0]  r_sw_sync1;
    logic [4:0]  r_sw_sync2;
    logic        r_run;
    logic        r_step;
    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_in;
    logic [4:0]  w_in_nxt;
    logic        w_step_rise;
    logic        w_valid_rise;
    logic        w_step_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_sw_sync1 <= '0;
            r_sw_sync2 <= '0;
        end else begin
            r_sync1    <= {sw_run, btn_valid, btn_step};
            r_sync2    <= r_sync1;
            r_sw_sync1 <= sw_in;
            r_sw_sync2 <= r_sw_sync1;
        end
    end

    // Level flips only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_db   <= '0;
            r_db_d <= '0;
            r_run  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_db_d <= r_db[1:0];
            r_run  <= r_db[2];
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_TC) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 24'd1;
                end
            end
        end
    end

    assign w_step_rise  = r_db[0] & ~r_db_d[0];
    assign w_valid_rise = r_db[1] & ~r_db_d[1];

`ifdef AUTO_STEP_EN
    logic [23:0] r_rep_cnt;
    logic        w_held;
    logic        w_rep_hit;

    assign w_held    = r_db[0] & r_db_d[0];
    assign w_rep_hit = w_held & (r_rep_cnt == REP_TC);

    // Counter starts from zero on the cycle after the initial pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rep_cnt <= '0;
        end else if (!w_held || w_rep_hit) begin
            r_rep_cnt <= '0;
        end else begin
            r_rep_cnt <= r_rep_cnt + 24'd1;
        end
    end

    assign w_step_nxt = w_step_rise | w_rep_hit;
`else
    logic w_unused_rep;

    assign w_unused_rep = ^REP_TC;
    assign w_step_nxt   = w_step_rise;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_step <= 1'b0;
        end else begin
            r_step <= w_step_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_in    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_in    <= w_in_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_nxt    = r_in;
        case (r_state)
            S_IDLE: begin
                if (w_valid_rise) begin
                    w_in_nxt    = r_sw_sync2;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (ready) begin
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (!r_db[1]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign step  = r_step;
    assign run   = r_run;
    assign in    = r_in;
    assign valid = (r_state == S_SEND);
    assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_dbg_cmd_gen.sv
// Bench for dbg_cmd_gen: event-level reference model checked every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_dbg_cmd_gen;
    localparam int DB  = 4;
    localparam int REP = 8;
`ifdef AUTO_STEP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_step = 1'b0;
    logic       btn_valid = 1'b0;
    logic       sw_run = 1'b0;
    logic [4:0] sw_in = 5'd0;
    logic       ready = 1'b0;
    logic       step;
    logic       run;
    logic [4:0] d_in;
    logic       valid;
    logic       busy;

    int checks = 0;
    int failures = 0;
    bit m_on = 1'b0;

    dbg_cmd_gen #(.DB_CYCLES(DB), .REPEAT_CYCLES(REP)) dut (
        .clk(clk), .rst(rst), .btn_step(btn_step), .btn_valid(btn_valid),
        .sw_run(sw_run), .sw_in(sw_in), .ready(ready),
        .step(step), .run(run), .in(d_in), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: raw -> 2-cycle delay -> stable-run filter -> events
    bit [2:0] ms1, ms2, mlvl, lvl_old;
    int       mcnt [3];
    bit [4:0] msw1, msw2, sw2_old, m_in;
    bit [1:0] m_rose;
    int       m_mode;
    bit       m_step, m_run;
    int       m_cyc, m_last;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms1 = 0; ms2 = 0; mlvl = 0; msw1 = 0; msw2 = 0; m_in = 0;
            m_rose = 0; m_mode = 0; m_step = 0; m_run = 0; m_cyc = 0; m_last = 0;
            for (int i = 0; i < 3; i++) mcnt[i] = 0;
        end else begin
            lvl_old = mlvl;
            sw2_old = msw2;
            m_cyc++;
            m_step = m_rose[0] || (AUTO && lvl_old[0] && (m_cyc - m_last == REP));
            if (m_step) m_last = m_cyc;
            m_run = lvl_old[2];
            case (m_mode)
                0: if (m_rose[1]) begin m_in = sw2_old; m_mode = 1; end
                1: if (ready) m_mode = 2;
                default: if (!lvl_old[1]) m_mode = 0;
            endcase
            m_rose = 0;
            for (int i = 0; i < 3; i++) begin
                if (ms2[i] != lvl_old[i]) begin
                    mcnt[i]++;
                    if (mcnt[i] == DB) begin
                        mlvl[i] = ms2[i];
                        mcnt[i] = 0;
                        if (i < 2 && ms2[i]) m_rose[i] = 1'b1;
                    end
                end else begin
                    mcnt[i] = 0;
                end
            end
            ms2 = ms1;
            ms1 = {sw_run, btn_valid, btn_step};
            msw2 = msw1;
            msw1 = sw_in;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("model_step", step, m_step);
            chk("model_run", run, m_run);
            chk("model_in", d_in, m_in);
            chk("model_valid", valid, m_mode == 1);
            chk("model_busy", busy, m_mode != 0);
        end
    end

    int pulses;
    int bad;
    int found;
    int offs[$];
    int exp_offs[$];

    initial begin
        repeat (3) @(negedge clk);
        m_on = 1'b1;
        chk("reset_step", step, 0);
        chk("reset_valid", valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_in", d_in, 0);
        chk("reset_run", run, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // run latency: 2 + DB + 1
        sw_run = 1'b1;
        repeat (6) @(negedge clk);
        chk("run_latency_early", run, 0);
        @(negedge clk);
        chk("run_latency", run, 1);

        // bouncing step button, then stable high
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            btn_step = (i % 2 == 0);
        end
        @(negedge clk);
        btn_step = 1'b1;
        pulses = 0;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            if (step) pulses++;
            if (j == 6) chk("bounce_no_early", step, 0);
            if (j == 7) begin
                chk("bounce_pulse_at7", step, 1);
                chk("model_pin_step7", m_step, 1);
            end
            if (j == 8) chk("bounce_width1", step, 0);
        end
        chk("bounce_pulse_count", pulses, 1);
        btn_step = 1'b0;
        repeat (10) @(negedge clk);

        // capture and handshake with ready delayed 10 cycles
        sw_in = 5'h15;
        btn_valid = 1'b1;
        repeat (7) @(negedge clk);
        chk("cap_valid", valid, 1);
        chk("cap_in", d_in, 5'h15);
        chk("model_pin_in", m_in, 5'h15);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (valid !== 1'b1 || d_in !== 5'h15) bad++;
            @(negedge clk);
        end
        chk("send_hold_10", bad, 0);
        ready = 1'b1;
        @(negedge clk);
        chk("hs_valid_drop", valid, 0);
        chk("hs_busy_release", busy, 1);
        btn_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("release_busy_held", busy, 1);
        @(negedge clk);
        chk("release_busy_drop", busy, 0);
        ready = 1'b0;
        repeat (5) @(negedge clk);

        // re-press during SEND is ignored
        sw_in = 5'h15;
        btn_valid = 1'b1;
        repeat (7) @(negedge clk);
        btn_valid = 1'b0;
        repeat (10) @(negedge clk);
        sw_in = 5'h0A;
        btn_valid = 1'b1;
        repeat (12) @(negedge clk);
        chk("repress_in_kept", d_in, 5'h15);
        chk("repress_valid", valid, 1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("repress_hs", valid, 0);
        btn_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("in_held_after_hs", d_in, 5'h15);

        // simultaneous step and valid
        sw_in = 5'h07;
        btn_step = 1'b1;
        btn_valid = 1'b1;
        repeat (6) @(negedge clk);
        chk("simul_step_early", step, 0);
        chk("simul_valid_early", valid, 0);
        @(negedge clk);
        chk("simul_step", step, 1);
        chk("simul_valid", valid, 1);
        chk("simul_in", d_in, 5'h07);

        // asynchronous reset mid-SEND
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_step", step, 0);
        chk("arst_in", d_in, 0);
        chk("arst_run", run, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (7) @(negedge clk);
        chk("held_after_rst_step", step, 1);
        chk("held_after_rst_valid", valid, 1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        btn_step = 1'b0;
        btn_valid = 1'b0;
        repeat (15) @(negedge clk);

        // hold step: auto-repeat schedule
        btn_step = 1'b1;
        found = 0;
        for (int w = 0; w < 20 && found == 0; w++) begin
            @(negedge clk);
            if (step) found = 1;
        end
        if (found == 0) chk("repeat_first_timeout", 0, 1);
        offs.delete();
        offs.push_back(0);
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk);
            if (step) offs.push_back(j);
            if (j == 23) btn_step = 1'b0;
        end
        exp_offs.delete();
        exp_offs.push_back(0);
        if (AUTO) begin
            exp_offs.push_back(8);
            exp_offs.push_back(16);
            exp_offs.push_back(24);
        end
        chk("repeat_count", offs.size(), exp_offs.size());
        for (int i = 0; i < exp_offs.size() && i < offs.size(); i++)
            chk("repeat_offset", offs[i], exp_offs[i]);

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) btn_step = ~btn_step;
            if ($urandom_range(0, 7) == 0) btn_valid = ~btn_valid;
            if ($urandom_range(0, 7) == 0) sw_run = ~sw_run;
            if ($urandom_range(0, 3) == 0) sw_in = 5'($urandom);
            ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 599) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
